// File: rtl/shift_ctrl.sv
// shift_ctrl: sequences loads and shifts of an external right-shift register,
// counting out a configurable number of serial bits per word with an optional idle gap.
module shift_ctrl #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] cfg_len,
  output logic [WIDTH-1:0] sr_data,
  output logic             sr_in_enable,
  output logic             sr_shift_enable,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic [CNT_W-1:0] bit_idx,
  output logic             busy,
  output logic             done
);
  localparam int GW = GAP > 0 ? $clog2(GAP+1) : 1;
  localparam logic [GW-1:0] GLAST = GW'(GAP > 0 ? GAP-1 : 0);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;
  state_t st, nxt;
  logic [CNT_W-1:0] cnt, len, eff;
  logic [GW-1:0] gcnt;
  logic last;
  assign eff  = (cfg_len == '0 || cfg_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cfg_len;
  assign last = cnt == len - CNT_W'(1);
  always_comb begin
    in_ready        = st == S_IDLE;
    sr_in_enable    = st == S_LOAD;
    ser_valid       = st == S_SHIFT;
    sr_shift_enable = ser_valid && ser_ready;
    bit_idx         = ser_valid ? cnt : '0;
    busy            = st != S_IDLE;
    done            = sr_shift_enable && last;
    nxt = st == S_IDLE  ? (in_valid ? S_LOAD : S_IDLE) :
          st == S_LOAD  ? S_SHIFT :
          st == S_SHIFT ? (done ? (GAP > 0 ? S_GAP : S_IDLE) : S_SHIFT) :
                          (gcnt == GLAST ? S_IDLE : S_GAP);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= S_IDLE;
      cnt     <= '0;
      len     <= '0;
      gcnt    <= '0;
      sr_data <= '0;
    end else begin
      st <= nxt;
      if (in_ready && in_valid) begin
        sr_data <= in_data;
        len     <= eff;
      end
      if (sr_in_enable) cnt <= '0;
      else if (sr_shift_enable && !last) cnt <= cnt + CNT_W'(1);
      gcnt <= st == S_GAP ? gcnt + GW'(1) : '0;
    end
  end
endmodule

// File: tb/tb_shift_ctrl.sv
// tb_shift_ctrl: randomized word/backpressure stimulus against a transaction-level
// expectation of bit order, length clamping, timing and gap spacing.
module tb_shift_ctrl;
  logic clk = 0, rst = 0;
  logic in_valid = 0, in_ready, sr_in_enable, sr_shift_enable, ser_valid, ser_ready = 0, busy, done;
  logic [7:0] in_data = 0, sr_data, sreg;
  logic [3:0] cfg_len = 0, bit_idx;
  logic iv2 = 0, ir2, sie2, sse2, sv2, srdy2 = 0, busy2, done2;
  logic [7:0] id2 = 0, sd2;
  logic [3:0] cl2 = 0, bi2;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  shift_ctrl #(.WIDTH(8), .GAP(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_len(cfg_len), .sr_data(sr_data), .sr_in_enable(sr_in_enable),
    .sr_shift_enable(sr_shift_enable), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .bit_idx(bit_idx), .busy(busy), .done(done));

  shift_ctrl #(.WIDTH(8), .GAP(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .cfg_len(cl2), .sr_data(sd2), .sr_in_enable(sie2),
    .sr_shift_enable(sse2), .ser_valid(sv2), .ser_ready(srdy2),
    .bit_idx(bi2), .busy(busy2), .done(done2));

  // external shift register: load has priority over shift
  always_ff @(posedge clk or negedge rst)
    if (!rst) sreg <= '0;
    else if (sr_in_enable) sreg <= sr_data;
    else if (sr_shift_enable) sreg <= {1'b0, sreg[7:1]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_word(input logic [7:0] d, input int cfg, input int stall_at,
                         input int stall_n, input bit rnd, output int cyc);
    int L, i, st;
    bit rdy;
    L = (cfg == 0 || cfg > 8) ? 8 : cfg;
    chk("idle_ready", in_ready, 1);
    in_valid = 1; in_data = d; cfg_len = cfg[3:0];
    @(posedge clk); @(negedge clk);
    in_valid = 0; in_data = 8'($urandom); cfg_len = 4'($urandom);
    #1;
    chk("load_en", sr_in_enable, 1);
    chk("load_data", sr_data, d);
    chk("load_ready", in_ready, 0);
    chk("load_sv", ser_valid, 0);
    chk("load_busy", busy, 1);
    @(posedge clk); @(negedge clk);
    i = 0; st = 0; cyc = 0;
    while (i < L && cyc < 300) begin
      rdy = rnd ? ($urandom_range(0, 3) != 0) : !(i == stall_at && st < stall_n);
      if (!rdy) st++;
      ser_ready = rdy;
      cfg_len = 4'($urandom);
      #1;
      chk("sv", ser_valid, 1);
      chk("idx", bit_idx, i);
      chk("lsb", sreg[0], (d >> i) & 1);
      chk("shift_en", sr_shift_enable, rdy);
      chk("done", done, rdy && i == L - 1);
      chk("no_load", sr_in_enable, 0);
      cyc++;
      if (rdy) i++;
      @(posedge clk); @(negedge clk);
    end
    chk("len_reached", i, L);
    ser_ready = 1'($urandom);
    #1;
    chk("post_ready", in_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
    chk("post_hold", sr_data, d);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, a1, d1, a2;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1; #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_load", sr_in_enable, 0);
    chk("rst_shift", sr_shift_enable, 0);
    chk("rst_sv", ser_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_data", sr_data, 0);
    chk("rst_idx", bit_idx, 0);
    @(negedge clk);
    do_word(8'hA5, 8, -1, 0, 0, cyc);
    chk("a5_cycles", cyc, 8);
    do_word(8'h6B, 3, 1, 2, 0, cyc);
    chk("stall_cycles", cyc, 5);
    do_word(8'hC3, 0, -1, 0, 0, cyc);
    chk("clamp0_cycles", cyc, 8);
    do_word(8'h3C, 12, -1, 0, 0, cyc);
    chk("clamp12_cycles", cyc, 8);
    do_word(8'h5E, 3, -1, 0, 0, cyc);
    chk("len3_cycles", cyc, 3);
    for (int k = 0; k < 20; k++) do_word(8'($urandom), int'($urandom_range(0, 15)), -1, 0, 1, cyc);
    // GAP=2 instance with in_valid held high
    iv2 = 1; cl2 = 2; srdy2 = 1; a1 = -1; d1 = -1; a2 = -1;
    for (int c = 0; c < 40 && a2 < 0; c++) begin
      id2 = 8'($urandom);
      #1;
      if (ir2 && iv2) begin
        if (a1 < 0) a1 = c;
        else if (d1 >= 0) a2 = c;
      end
      if (done2 && d1 < 0) d1 = c;
      if (d1 >= 0 && (c == d1 + 1 || c == d1 + 2)) chk("gap_ready", ir2, 0);
      @(posedge clk); @(negedge clk);
    end
    iv2 = 0;
    chk("gap_done_lat", d1 - a1, 3);
    chk("gap_reaccept", a2 - d1, 3);
    // reset in the middle of a word
    ser_ready = 1; in_valid = 1; in_data = 8'hFF; cfg_len = 8;
    @(posedge clk); @(negedge clk);
    in_valid = 0;
    for (int g = 0; g < 20 && !(ser_valid && bit_idx == 4); g++) begin
      @(posedge clk); @(negedge clk);
    end
    chk("mid_idx", bit_idx, 4);
    rst = 0; #1;
    chk("mid_ready", in_ready, 1);
    chk("mid_busy", busy, 0);
    chk("mid_sv", ser_valid, 0);
    chk("mid_done", done, 0);
    chk("mid_shift", sr_shift_enable, 0);
    chk("mid_idx0", bit_idx, 0);
    chk("mid_data", sr_data, 0);
    @(posedge clk); @(negedge clk);
    rst = 1;
    @(negedge clk);
    do_word(8'h96, 5, -1, 0, 0, cyc);
    chk("after_rst_cycles", cyc, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_ctrl.md
Name: shift_ctrl

Overview:
- Sequencing controller for the team's parallel-load, right-shift register (load enable has priority over shift enable; shifts one bit per enabled cycle).
- Accepts parallel words over a valid/ready handshake and drives the register's data, load enable and shift enable.
- Counts out a configurable number of serial bits under a downstream ready handshake, then inserts an optional idle gap between words.
- Sits between a word producer and a bit-serial consumer. It observes the register's LSB as the serial bit.

Parameters:
- WIDTH, 8, word width and maximum bits per word.
- GAP, 0, idle cycles inserted after each word before the next word is accepted; 0 means no gap.
- CNT_W, $clog2(WIDTH+1), width of the bit counter and of cfg_len.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  controller can accept a word this cycle.
- in_data  input  WIDTH  parallel word.
- cfg_len  input  CNT_W  number of bits to send; sampled at accept.
- sr_data  output  WIDTH  data to the shift register's parallel input.
- sr_in_enable  output  1  load strobe to the shift register.
- sr_shift_enable  output  1  shift strobe to the shift register.
- ser_valid  output  1  the register LSB is a valid serial bit this cycle.
- ser_ready  input  1  consumer accepts the serial bit this cycle.
- bit_idx  output  CNT_W  index of the current bit, 0 = first bit.
- busy  output  1  asserted in any state other than IDLE.
- done  output  1  one-cycle pulse on the cycle the last bit transfers.

Behaviour:
- FSM states: IDLE, LOAD, SHIFT, GAP.
- Reset (rst=0, asynchronous):
  - State goes to IDLE; counter and gap counter go to 0; sr_data goes to 0.
  - sr_in_enable=0, sr_shift_enable=0, ser_valid=0, done=0, busy=0, bit_idx=0, in_ready=1.
  - Reset mid-word abandons the word with no done pulse. The shift register shares rst.
- IDLE:
  - in_ready=1.
  - Accept occurs when in_valid=1 in IDLE. On accept: register in_data into sr_data, latch the effective length, go to LOAD.
  - Effective length: cfg_len=0 or cfg_len>WIDTH gives WIDTH; otherwise cfg_len.
- LOAD (exactly 1 cycle):
  - sr_in_enable=1, in_ready=0.
  - The register loads at the end of this cycle.
  - Counter cleared to 0; next state SHIFT.
- SHIFT:
  - ser_valid=1, bit_idx=counter.
  - sr_shift_enable = ser_ready, so the register shifts only after a bit transfers.
  - When ser_ready=1 and counter < len-1: counter increments.
  - When ser_ready=1 and counter = len-1: done=1 that cycle, then go to GAP if GAP>0, else IDLE.
  - When ser_ready=0: hold counter and state; no shift.
- GAP:
  - Lasts exactly GAP cycles, counted by the gap counter; in_ready=0, ser_valid=0.
  - Then go to IDLE.
- Latency:
  - Accept cycle to first ser_valid is 2 cycles (accept, LOAD, then SHIFT).
  - With ser_ready held at 1, a word occupies 2+len cycles, plus GAP cycles if GAP>0.
- Throughput: there are no back-to-back accepts. Earliest re-accept is the cycle after the done cycle (GAP=0).
- sr_in_enable and sr_shift_enable are never asserted in the same cycle.
- in_data and cfg_len are ignored outside accept cycles.
- sr_data holds its value until the next accept.
- A cfg_len change during SHIFT has no effect on the word in progress.

Test Plan:
- Reset then idle: rst low for 2 cycles, release -> in_ready=1, busy=0, all strobes 0, sr_data=0.
- Single word, WIDTH=8, cfg_len=8, in_data=8'hA5, ser_ready=1 throughout:
  - LOAD one cycle after accept, with sr_in_enable=1 and sr_data=A5.
  - Then 8 SHIFT cycles with bit_idx 0..7; LSB sequence 1,0,1,0,0,1,0,1.
  - done pulses on bit_idx=7; in_ready=1 on the next cycle.
- Backpressure: cfg_len=3, ser_ready low on bit_idx=1 for 2 cycles -> bit_idx holds at 1, sr_shift_enable=0 during the stall, done arrives 2 cycles later than unstalled.
- Length clamp: cfg_len=0 then cfg_len=12 (WIDTH=8) -> both send exactly 8 bits; a cfg_len=3 word sends 3 bits then returns to IDLE.
- GAP=2, two words offered back-to-back with in_valid held high -> second accept occurs exactly 3 cycles after the first word's done cycle (2 GAP cycles + 1 IDLE).
- Reset mid-word: assert rst during bit_idx=4 -> outputs immediately at reset values, no done pulse; a new word is accepted cleanly after release.
